// File: rtl/avalon_interconnect.sv
// avalon_interconnect: shared-bus Avalon-MM interconnect with round-robin host arbitration,
// one outstanding transaction, lowest-index address decode and sticky decode-miss capture.
module avalon_interconnect #(
    parameter int NH = 3,
    parameter int ND = 5,
    parameter logic [ND*32-1:0] DEV_BASE = '0,
    parameter logic [ND*32-1:0] DEV_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NH-1:0]    h_read,
    input  logic [NH-1:0]    h_write,
    input  logic [NH*32-1:0] h_address,
    input  logic [NH*32-1:0] h_writedata,
    input  logic [NH*4-1:0]  h_byte_enable,
    output logic [NH*32-1:0] h_readdata,
    output logic [NH-1:0]    h_waitrequest,
    output logic [ND-1:0]    d_read,
    output logic [ND-1:0]    d_write,
    output logic [ND*32-1:0] d_address,
    output logic [ND*32-1:0] d_writedata,
    output logic [ND*4-1:0]  d_byte_enable,
    input  logic [ND*32-1:0] d_readdata,
    input  logic [ND-1:0]    d_waitrequest,
    output logic             decode_err,
    output logic [31:0]      err_addr
);
    localparam int HW = NH > 1 ? $clog2(NH) : 1;
    localparam int DW = ND > 1 ? $clog2(ND) : 1;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, win, idx, grant_nxt;
    logic [DW-1:0] dev_q, dev_d, win_dev;
    logic          decode_err_q, decode_err_d, win_hit, done, g_rd, g_wr;
    logic [31:0]   err_addr_q, err_addr_d, win_addr, g_addr, g_wdata;
    logic [3:0]    g_be;
    logic [NH-1:0] req;
    logic [31:0]   h_addr [NH];
    logic [31:0]   h_wdata [NH];
    logic [3:0]    h_be [NH];
    logic [31:0]   d_rdata [ND];

    assign req = h_read | h_write;

    for (genvar h = 0; h < NH; h++) begin : g_host_in
        assign h_addr[h]  = h_address[32*h +: 32];
        assign h_wdata[h] = h_writedata[32*h +: 32];
        assign h_be[h]    = h_byte_enable[4*h +: 4];
    end

    // Scan downward so the requester closest to rr_ptr (smallest offset) is written last and wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NH - 1; i >= 0; i--) begin
            idx = HW'((int'(rr_ptr_q) + i) % NH);
            if (req[idx]) win = idx;
        end
    end

    assign win_addr = h_addr[win];

    always_comb begin
        win_hit = 1'b0;
        win_dev = '0;
        for (int d = ND - 1; d >= 0; d--)
            if ((win_addr & DEV_MASK[32*d +: 32]) == DEV_BASE[32*d +: 32]) begin
                win_hit = 1'b1;
                win_dev = DW'(d);
            end
    end

    assign g_wr      = h_write[grant_q];
    assign g_rd      = h_read[grant_q] & ~g_wr;
    assign g_addr    = h_addr[grant_q];
    assign g_wdata   = h_wdata[grant_q];
    assign g_be      = h_be[grant_q];
    assign done      = !d_waitrequest[dev_q] || !req[grant_q];
    assign grant_nxt = grant_q == HW'(NH - 1) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        dev_d        = dev_q;
        rr_ptr_d     = rr_ptr_q;
        decode_err_d = decode_err_q;
        err_addr_d   = err_addr_q;
        if (state_q == IDLE && |req) begin
            grant_d      = win;
            dev_d        = win_dev;
            state_d      = win_hit ? BUSY : ERR;
            decode_err_d = decode_err_q | ~win_hit;
            err_addr_d   = (!win_hit && !decode_err_q) ? win_addr : err_addr_q;
        end else if ((state_q == BUSY && done) || state_q == ERR) begin
            rr_ptr_d = grant_nxt;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            dev_q        <= '0;
            rr_ptr_q     <= '0;
            decode_err_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            dev_q        <= dev_d;
            rr_ptr_q     <= rr_ptr_d;
            decode_err_q <= decode_err_d;
            err_addr_q   <= err_addr_d;
        end
    end

    for (genvar d = 0; d < ND; d++) begin : g_dev
        logic sel;
        assign sel                     = state_q == BUSY && dev_q == DW'(d);
        assign d_rdata[d]              = d_readdata[32*d +: 32];
        assign d_read[d]               = sel & g_rd;
        assign d_write[d]              = sel & g_wr;
        assign d_address[32*d +: 32]   = sel ? g_addr : '0;
        assign d_writedata[32*d +: 32] = sel ? g_wdata : '0;
        assign d_byte_enable[4*d +: 4] = sel ? g_be : '0;
    end

    for (genvar h = 0; h < NH; h++) begin : g_host_out
        logic me;
        assign me                     = grant_q == HW'(h);
        assign h_waitrequest[h]       = !(me && (state_q == ERR || (state_q == BUSY && !d_waitrequest[dev_q])));
        assign h_readdata[32*h +: 32] = (me && state_q == BUSY) ? d_rdata[dev_q] : '0;
    end

    assign decode_err = decode_err_q;
    assign err_addr   = err_addr_q;
endmodule
